piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in serial-out transmitter; the transmitting end of the serial link whose receiving end is the shift_reg block (serial D in, parallel P out).
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on ser_o.
- ser_en_o qualifies each bit, so it can drive the receiver's shift mode directly.
- Signals end of word with a one-cycle done pulse.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first (matches a left-shifting receiver); 0 = transmit bit 0 first (matches a right-shifting receiver).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nrst  in  1  asynchronous active-low reset.
- par_i  in  WIDTH  parallel word to transmit; sampled only on an accepted handshake.
- valid_i  in  1  producer has a word on par_i.
- ready_o  out  1  transmitter can accept a word this cycle.
- ser_o  out  1  serial data bit.
- ser_en_o  out  1  high when ser_o carries a valid data bit (or the parity bit).
- busy_o  out  1  high while a word is being shifted out.
- done_o  out  1  one-cycle pulse after the final bit of a word.

Behaviour:
- Reset (nrst=0, asynchronous):
  - state=IDLE; shift register, bit counter, ser_o, ser_en_o, busy_o and done_o all 0.
  - ready_o=1, because it is decoded from IDLE.
  - No transfer can be accepted while nrst=0.
- States: IDLE, SHIFT.
- Handshake:
  - Transfer accepted on a rising edge where valid_i=1 and ready_o=1.
  - ready_o = (state==IDLE) || (state==SHIFT && last beat).
  - valid_i asserted while ready_o=0 is stalled, not dropped. The producer holds valid_i and par_i until accepted.
  - par_i changes after acceptance do not affect the word in flight.
- IDLE -> SHIFT on acceptance:
  - par_i is loaded into the internal shift register and the bit counter is cleared.
- Latency: the first bit appears on ser_o with ser_en_o=1 in the cycle immediately after the accepting edge. All outputs are registered; no combinational path from par_i or valid_i to ser_o.
- SHIFT:
  - One bit per cycle; ser_en_o=1, busy_o=1.
  - MSB_FIRST=1: output order bit WIDTH-1 down to bit 0.
  - MSB_FIRST=0: output order bit 0 up to bit WIDTH-1.
  - The bit counter runs 0..BEATS-1. BEATS = WIDTH (WIDTH+1 with parity enabled).
- Last beat (counter==BEATS-1):
  - No acceptance: next state IDLE. ser_o=0, ser_en_o=0, busy_o=0 in the following cycle.
  - Acceptance (back-to-back): stay in SHIFT and reload from par_i. The first bit of the new word follows the last bit of the old one with no gap cycle.
- done_o:
  - Pulses for exactly one cycle, in the cycle after each word's last beat.
  - Also pulses when a back-to-back word is already shifting.
- Idle outputs: ser_o=0, ser_en_o=0, busy_o=0, done_o=0 (except the done pulse cycle).
- Reset mid-word: all outputs clear immediately; the partial word is discarded and never resumed.
- Counter width: clog2(WIDTH+1) bits; it never exceeds BEATS-1.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- When defined:
  - After the WIDTH data bits, one extra beat carries even parity (XOR of all WIDTH data bits) on ser_o, with ser_en_o=1.
  - BEATS = WIDTH+1; ready_o for back-to-back acceptance and the done_o timing follow the parity beat.
- When undefined: BEATS = WIDTH, no parity beat, and the parity logic is absent.

Test Plan:
1. Reset: hold nrst=0 with valid_i=1, par_i=8'hA5 for 2 cycles -> ser_o=0, ser_en_o=0, busy_o=0, done_o=0, ready_o=1. After release with valid_i=0, no ser_en_o for 4 cycles.
2. MSB_FIRST=1, accept 8'hA5 -> next 8 cycles: ser_o=1,0,1,0,0,1,0,1 with ser_en_o=1; cycle 9: done_o=1, ser_en_o=0. A shift_reg in LEFT mode gated by ser_en_o ends with P=8'hA5.
3. MSB_FIRST=0, accept 8'hAA -> ser_o=0,1,0,1,0,1,0,1. A shift_reg in RIGHT mode ends with P=8'hAA.
4. Back-to-back: valid_i held with 8'hFF, then switched to 8'h00 on the first word's last beat -> 16 consecutive ser_en_o=1 cycles (eight 1s then eight 0s). done_o pulses in cycles 9 and 17; ready_o=0 for beats 0-6 of each word.
5. Stall and mid-word reset:
   - valid_i=1 during beat 3 (not last) -> no acceptance until the last beat.
   - Then assert nrst=0 during beat 3 of 8'h3C -> outputs 0 immediately.
   - After release, send 8'h3C -> a full correct 8-bit stream and a single done pulse.
6. PISO_TX_PARITY_EN defined:
   - 8'h07 -> 8 data bits then parity bit 1; done_o in cycle 10.
   - 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/piso_tx_if.sv
// Word-side valid/ready handshake of the piso_tx serializer.
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] par_i;
  logic             valid_i;
  logic             ready_o;

  modport master (output par_i, output valid_i, input ready_o);
  modport slave  (input par_i, input valid_i, output ready_o);
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one word in over valid/ready, one bit per clock out.
// Define PISO_TX_PARITY_EN to append an even-parity beat after the data bits.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     nrst,
  piso_tx_if.slave in_if,
  output logic     ser_o,
  output logic     ser_en_o,
  output logic     busy_o,
  output logic     done_o
);

`ifdef PISO_TX_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             ser_q, ser_en_q, busy_q, done_q;

  logic             last, accept, first_bit, nxt_bit;
  logic [WIDTH-1:0] sh_d;

  assign last         = (state_q == SHIFT) && (cnt_q == LAST);
  assign in_if.ready_o = (state_q == IDLE) || last;
  assign accept       = in_if.valid_i && in_if.ready_o;

  // sh_q always holds the word aligned so the bit on ser_q sits at the output end;
  // the next bit is therefore the neighbour of that end.
  assign sh_d      = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
  assign first_bit = MSB_FIRST ? in_if.par_i[WIDTH-1] : in_if.par_i[0];

`ifdef PISO_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       par_q <= 1'b0;
    else if (accept) par_q <= ^in_if.par_i;
  end

  // Beat after the final data bit carries the parity captured at load.
  assign nxt_bit = (cnt_q == CW'(WIDTH - 1)) ? par_q
                 : (MSB_FIRST ? sh_q[WIDTH-2] : sh_q[1]);
`else
  assign nxt_bit = MSB_FIRST ? sh_q[WIDTH-2] : sh_q[1];
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      ser_q    <= 1'b0;
      ser_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        // Covers both the idle start and the gapless back-to-back reload.
        state_q  <= SHIFT;
        sh_q     <= in_if.par_i;
        cnt_q    <= '0;
        ser_q    <= first_bit;
        ser_en_q <= 1'b1;
        busy_q   <= 1'b1;
      end else if (last) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        ser_q    <= 1'b0;
        ser_en_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (state_q == SHIFT) begin
        sh_q  <= sh_d;
        cnt_q <= cnt_q + 1'b1;
        ser_q <= nxt_bit;
      end
    end
  end

  assign ser_o    = ser_q;
  assign ser_en_o = ser_en_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one MSB-first and one LSB-first instance, each feeding a
// shift_reg-style receiver model gated by ser_en_o.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int BEATS = 9;
`else
  localparam int BEATS = 8;
`endif

  logic clk = 1'b0;
  logic nrst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(8)) if_m ();
  piso_tx_if #(.WIDTH(8)) if_l ();

  logic ser_m, en_m, busy_m, done_m;
  logic ser_l, en_l, busy_l, done_l;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .nrst(nrst), .in_if(if_m),
    .ser_o(ser_m), .ser_en_o(en_m), .busy_o(busy_m), .done_o(done_m));

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .nrst(nrst), .in_if(if_l),
    .ser_o(ser_l), .ser_en_o(en_l), .busy_o(busy_l), .done_o(done_l));

  // {ser, ser_en, busy, done, ready}
  logic [4:0] ob_m, ob_l;
  assign ob_m = {ser_m, en_m, busy_m, done_m, if_m.ready_o};
  assign ob_l = {ser_l, en_l, busy_l, done_l, if_l.ready_o};

  logic [7:0] rx_m, rx_l;
  always @(posedge clk) if (en_m) rx_m <= {rx_m[6:0], ser_m};
  always @(posedge clk) if (en_l) rx_l <= {ser_l, rx_l[7:1]};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    if_m.valid_i = 1'b1; if_m.par_i = 8'hA5;
    if_l.valid_i = 1'b1; if_l.par_i = 8'hA5;
    #2;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_tests++;
      if (ob_m !== 5'b00001 || ob_l !== 5'b00001) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got msb=%b lsb=%b exp 00001", i, ob_m, ob_l);
      end
    end
    if_m.valid_i = 1'b0;
    if_l.valid_i = 1'b0;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_tests++;
      if (ob_m !== 5'b00001 || ob_l !== 5'b00001) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got msb=%b lsb=%b exp 00001", i, ob_m, ob_l);
      end
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] seq;
    logic [4:0] exp;
    seq = 8'b10100101;
    if_m.par_i = 8'hA5; if_m.valid_i = 1'b1;
    cyc();
    if_m.valid_i = 1'b0;
    if_m.par_i   = 8'h00;
    for (int i = 0; i < BEATS; i++) begin
      exp = {(i < 8) ? seq[3'(7 - i)] : 1'b0, 1'b1, 1'b1, 1'b0, i == BEATS - 1};
      n_tests++;
      if (ob_m !== exp) begin
        n_fail++;
        $display("FAIL msb_A5 beat %0d: got %b exp %b", i, ob_m, exp);
      end
      cyc();
    end
    n_tests++;
    if (ob_m !== 5'b00011) begin
      n_fail++;
      $display("FAIL msb_A5 done: got %b exp 00011", ob_m);
    end
    cyc();
    n_tests++;
    if (ob_m !== 5'b00001) begin
      n_fail++;
      $display("FAIL msb_A5 idle: got %b exp 00001", ob_m);
    end
`ifndef PISO_TX_PARITY_EN
    n_tests++;
    if (rx_m !== 8'hA5) begin
      n_fail++;
      $display("FAIL msb_A5 rx: got %h exp a5", rx_m);
    end
`endif
  endtask

  task automatic test_lsb_first();
    logic [7:0] seq;
    logic [4:0] exp;
    seq = 8'b01010101;
    if_l.par_i = 8'hAA; if_l.valid_i = 1'b1;
    cyc();
    if_l.valid_i = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      exp = {(i < 8) ? seq[3'(7 - i)] : 1'b0, 1'b1, 1'b1, 1'b0, i == BEATS - 1};
      n_tests++;
      if (ob_l !== exp) begin
        n_fail++;
        $display("FAIL lsb_AA beat %0d: got %b exp %b", i, ob_l, exp);
      end
      cyc();
    end
    n_tests++;
    if (ob_l !== 5'b00011) begin
      n_fail++;
      $display("FAIL lsb_AA done: got %b exp 00011", ob_l);
    end
`ifndef PISO_TX_PARITY_EN
    n_tests++;
    if (rx_l !== 8'hAA) begin
      n_fail++;
      $display("FAIL lsb_AA rx: got %h exp aa", rx_l);
    end
`endif
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    int b, w;
    if_m.par_i = 8'hFF; if_m.valid_i = 1'b1;
    cyc();
    for (int g = 0; g < 2 * BEATS; g++) begin
      b = g % BEATS;
      w = g / BEATS;
      if (g == BEATS - 1) if_m.par_i = 8'h00;
      if (g == BEATS)     if_m.valid_i = 1'b0;
      exp = {(w == 0) && (b < 8), 1'b1, 1'b1, g == BEATS, b == BEATS - 1};
      n_tests++;
      if (ob_m !== exp) begin
        n_fail++;
        $display("FAIL b2b beat %0d: got %b exp %b", g, ob_m, exp);
      end
      cyc();
    end
    n_tests++;
    if (ob_m !== 5'b00011) begin
      n_fail++;
      $display("FAIL b2b done: got %b exp 00011", ob_m);
    end
    cyc();
  endtask

  task automatic test_stall_and_reset();
    logic [7:0] s5a, sc3, s3c;
    logic [4:0] exp;
    s5a = 8'b01011010; sc3 = 8'b11000011; s3c = 8'b00111100;
    if_m.par_i = 8'h5A; if_m.valid_i = 1'b1;
    cyc();
    if_m.valid_i = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      if (i == 3) begin if_m.valid_i = 1'b1; if_m.par_i = 8'hC3; end
      exp = {(i < 8) ? s5a[3'(7 - i)] : 1'b0, 1'b1, 1'b1, 1'b0, i == BEATS - 1};
      n_tests++;
      if (ob_m !== exp) begin
        n_fail++;
        $display("FAIL stall_5A beat %0d: got %b exp %b", i, ob_m, exp);
      end
      cyc();
    end
    if_m.valid_i = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      exp = {(i < 8) ? sc3[3'(7 - i)] : 1'b0, 1'b1, 1'b1, i == 0, i == BEATS - 1};
      n_tests++;
      if (ob_m !== exp) begin
        n_fail++;
        $display("FAIL stall_C3 beat %0d: got %b exp %b", i, ob_m, exp);
      end
      cyc();
    end
    cyc();
    // Start 3C and reset it during beat 3.
    if_m.par_i = 8'h3C; if_m.valid_i = 1'b1;
    cyc();
    if_m.valid_i = 1'b0;
    repeat (3) cyc();
    n_tests++;
    if (ob_m !== 5'b11100) begin
      n_fail++;
      $display("FAIL midreset beat3: got %b exp 11100", ob_m);
    end
    nrst = 1'b0;
    #1;
    n_tests++;
    if (ob_m !== 5'b00001) begin
      n_fail++;
      $display("FAIL midreset async clear: got %b exp 00001", ob_m);
    end
    cyc();
    nrst = 1'b1;
    cyc();
    n_tests++;
    if (ob_m !== 5'b00001) begin
      n_fail++;
      $display("FAIL midreset no resume: got %b exp 00001", ob_m);
    end
    if_m.par_i = 8'h3C; if_m.valid_i = 1'b1;
    cyc();
    if_m.valid_i = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      exp = {(i < 8) ? s3c[3'(7 - i)] : 1'b0, 1'b1, 1'b1, 1'b0, i == BEATS - 1};
      n_tests++;
      if (ob_m !== exp) begin
        n_fail++;
        $display("FAIL resend_3C beat %0d: got %b exp %b", i, ob_m, exp);
      end
      cyc();
    end
    n_tests++;
    if (ob_m !== 5'b00011) begin
      n_fail++;
      $display("FAIL resend_3C done: got %b exp 00011", ob_m);
    end
    cyc();
    n_tests++;
    if (ob_m !== 5'b00001) begin
      n_fail++;
      $display("FAIL resend_3C single done: got %b exp 00001", ob_m);
    end
`ifndef PISO_TX_PARITY_EN
    n_tests++;
    if (rx_m !== 8'h3C) begin
      n_fail++;
      $display("FAIL resend_3C rx: got %h exp 3c", rx_m);
    end
`endif
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic       pbits [2];
    logic [4:0] exp;
    words[0] = 8'h07; pbits[0] = 1'b1;
    words[1] = 8'h03; pbits[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_m.par_i = words[k]; if_m.valid_i = 1'b1;
      cyc();
      if_m.valid_i = 1'b0;
      // MSB-first order of these words is their binary string, then the parity bit.
      for (int i = 0; i < 9; i++) begin
        exp = {(i < 8) ? words[k][3'(7 - i)] : pbits[k], 1'b1, 1'b1, 1'b0, i == 8};
        n_tests++;
        if (ob_m !== exp) begin
          n_fail++;
          $display("FAIL parity_%h beat %0d: got %b exp %b", words[k], i, ob_m, exp);
        end
        cyc();
      end
      n_tests++;
      if (ob_m !== 5'b00011) begin
        n_fail++;
        $display("FAIL parity_%h done: got %b exp 00011", words[k], ob_m);
      end
      cyc();
    end
  endtask
`endif

  initial begin
    if_m.valid_i = 1'b0; if_m.par_i = 8'h00;
    if_l.valid_i = 1'b0; if_l.par_i = 8'h00;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stall_and_reset();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
